// File: rtl/mul4_rr_sched_if.sv
// Requester/multiplier bus for mul4_rr_sched: operand handshake, shared multiplier lines, tagged responses.
// Combinational only; master is the requester/datapath side, slave is the scheduler.
interface mul4_rr_sched_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [4*NREQ-1:0] req_q;
    logic [4*NREQ-1:0] req_m;
    logic              mul_start;
    logic [3:0]        mul_q;
    logic [3:0]        mul_m;
    logic [7:0]        mul_p;
    logic [NREQ-1:0]   resp_valid;
    logic [7:0]        resp_data;
    logic [IDW-1:0]    resp_id;

    modport master (
        output req_valid, req_q, req_m, mul_p,
        input  req_ready, mul_start, mul_q, mul_m, resp_valid, resp_data, resp_id
    );

    modport slave (
        input  req_valid, req_q, req_m, mul_p,
        output req_ready, mul_start, mul_q, mul_m, resp_valid, resp_data, resp_id
    );
endinterface

// File: rtl/mul4_rr_sched.sv
// Round-robin scheduler feeding one shared pipelined 4x4 multiplier; MUL4_RR_SCHED_STATS_EN adds issue/stall counters.
// Latency: product returned LAT+2 cycles after the accepting cycle, in issue order, one op per cycle sustained.
// Backpressure: req_ready is a one-hot grant only while running; responses cannot be stalled.
module mul4_rr_sched #(
    parameter int NREQ = 4,
    parameter int LAT  = 3,
    parameter int IDW  = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    output logic           idle,
    mul4_rr_sched_if.slave bus
`ifdef MUL4_RR_SCHED_STATS_EN
    ,
    output logic [15:0]    issue_cnt,
    output logic [15:0]    stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
    } tag_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    tag_t            tag_q [LAT+1];
    tag_t            tag_d [LAT+1];
    logic [3:0]      mul_q_q, mul_q_d;
    logic [3:0]      mul_m_q, mul_m_d;
    logic [NREQ-1:0] resp_valid_q, resp_valid_d;
    logic [7:0]      resp_data_q, resp_data_d;
    logic [IDW-1:0]  resp_id_q, resp_id_d;

    logic            issue_en;
    logic            start;
    logic            tags_empty;
    logic            gnt_found;
    logic [IDW-1:0]  gnt_id;
    logic            xfer;
    logic [NREQ-1:0] vld_rot;
    logic [IDW:0]    cand;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (en) state_d = S_RUN;
            S_RUN:   if (!en) state_d = S_DRAIN;
            S_DRAIN: begin
                if (en) begin
                    state_d = S_RUN;
                end else if (tags_empty) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The multiplier and tag pipeline advance together on every non-idle cycle.
    always_comb begin
        issue_en = (state_q == S_RUN);
        start    = (state_q != S_IDLE);
        idle     = (state_q == S_IDLE) && tags_empty;
    end

    always_comb begin
        tags_empty = 1'b1;
        for (int i = 0; i <= LAT; i++) begin
            if (tag_q[i].vld) tags_empty = 1'b0;
        end
    end

    // Rotate valids so bit 0 is the pointer position; descending scan lets the nearest one win.
    always_comb begin
        vld_rot   = NREQ'({bus.req_valid, bus.req_valid} >> ptr_q);
        cand      = '0;
        gnt_found = 1'b0;
        gnt_id    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (vld_rot[k]) begin
                cand = {1'b0, ptr_q} + (IDW+1)'(k);
                if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
                gnt_found = 1'b1;
                gnt_id    = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        xfer          = issue_en && gnt_found;
        bus.req_ready = '0;
        if (xfer) bus.req_ready[gnt_id] = 1'b1;

        ptr_d = ptr_q;
        if (xfer) ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;

        mul_q_d = xfer ? bus.req_q[{gnt_id, 2'b00} +: 4] : 4'd0;
        mul_m_d = xfer ? bus.req_m[{gnt_id, 2'b00} +: 4] : 4'd0;

        for (int i = 0; i <= LAT; i++) tag_d[i] = tag_q[i];
        if (start) begin
            tag_d[0].vld = xfer;
            tag_d[0].id  = xfer ? gnt_id : '0;
            for (int i = 1; i <= LAT; i++) tag_d[i] = tag_q[i-1];
        end

        // Last tag stage lines up with the product currently on mul_p.
        resp_valid_d = '0;
        resp_data_d  = resp_data_q;
        resp_id_d    = resp_id_q;
        if (tag_q[LAT].vld) begin
            resp_valid_d[tag_q[LAT].id] = 1'b1;
            resp_data_d                 = bus.mul_p;
            resp_id_d                   = tag_q[LAT].id;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q        <= '0;
            mul_q_q      <= '0;
            mul_m_q      <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            resp_id_q    <= '0;
            for (int i = 0; i <= LAT; i++) tag_q[i] <= '0;
        end else begin
            ptr_q        <= ptr_d;
            mul_q_q      <= mul_q_d;
            mul_m_q      <= mul_m_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_id_q    <= resp_id_d;
            for (int i = 0; i <= LAT; i++) tag_q[i] <= tag_d[i];
        end
    end

    assign bus.mul_start  = start;
    assign bus.mul_q      = mul_q_q;
    assign bus.mul_m      = mul_m_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_id    = resp_id_q;

`ifdef MUL4_RR_SCHED_STATS_EN
    logic [15:0] issue_cnt_q, issue_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        issue_cnt_d = issue_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (xfer && (issue_cnt_q != 16'hFFFF)) issue_cnt_d = issue_cnt_q + 16'd1;
        if (issue_en && (|bus.req_valid) && !xfer && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign issue_cnt = issue_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mul4_rr_sched.sv
// Bench for mul4_rr_sched: behavioural model of grants, operand drive, response timing and idle, plus a shared multiplier model.
module tb_mul4_rr_sched;
    localparam int NREQ = 4;
    localparam int LAT  = 3;
    localparam int IDW  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic idle;

    always #5 clk = ~clk;

    mul4_rr_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    mul4_rr_sched #(.NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .idle  (idle),
        .bus   (bus)
    );

    // Shared multiplier: samples operands when start is high, product LAT cycles later.
    logic [7:0] mp [LAT] = '{default: 8'd0};
    always @(posedge clk) begin
        if (bus.mul_start) begin
            mp[0] <= 8'(bus.mul_q) * 8'(bus.mul_m);
            for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
        end
    end
    assign bus.mul_p = mp[LAT-1];

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        int due;
        int id;
        int prod;
    } rsp_t;

    int   cyc = 0;
    bit   en_h1, en_h2;
    int   ptr_m;
    int   issue_t [$];
    rsp_t rsp_q [$];
    int   last_data;
    bit   prev_x;
    logic [3:0] prev_q, prev_m;

    int              exp_g;
    logic [3:0]      gq, gm;
    logic [NREQ-1:0] exp_ready, exp_rv;
    logic [3:0]      exp_mq, exp_mm;
    logic [7:0]      exp_rd;
    logic [IDW-1:0]  exp_rid;
    logic            exp_idle, exp_start;

    task automatic model_clear();
        en_h1 = 0; en_h2 = 0; ptr_m = 0; last_data = 0; prev_x = 0;
        prev_q = '0; prev_m = '0;
        issue_t.delete();
        rsp_q.delete();
    endtask

    task automatic set_req(input int i, input bit v, input logic [3:0] q, input logic [3:0] m);
        bus.req_valid[i]     = v;
        bus.req_q[4*i +: 4]  = q;
        bus.req_m[4*i +: 4]  = m;
    endtask

    // Running means en was high last cycle; idle means two quiet en cycles and nothing issued recently.
    task automatic settle();
        int g;
        bit busy;
        g = -1;
        busy = 0;
        if (en_h1) begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (ptr_m + k) % NREQ;
                if (g < 0 && bus.req_valid[i]) g = i;
            end
        end
        exp_g = g;
        exp_ready = '0;
        if (g >= 0) begin
            exp_ready[g] = 1'b1;
            gq = bus.req_q[4*g +: 4];
            gm = bus.req_m[4*g +: 4];
        end
        exp_mq = prev_x ? prev_q : 4'd0;
        exp_mm = prev_x ? prev_m : 4'd0;
        exp_rv = '0;
        exp_rd = 8'(last_data);
        exp_rid = '0;
        if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
            exp_rv[rsp_q[0].id] = 1'b1;
            exp_rd  = 8'(rsp_q[0].prod);
            exp_rid = IDW'(rsp_q[0].id);
        end
        foreach (issue_t[j]) if (issue_t[j] >= cyc - 2 - LAT && issue_t[j] <= cyc - 2) busy = 1;
        exp_idle  = !en_h1 && !en_h2 && !busy;
        exp_start = !exp_idle;
        @(negedge clk);
    endtask

    task automatic advance();
        if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
            last_data = rsp_q[0].prod;
            rsp_q.delete(0);
        end
        if (exp_g >= 0) begin
            rsp_q.push_back('{due: cyc + LAT + 2, id: exp_g, prod: int'(gq) * int'(gm)});
            issue_t.push_back(cyc);
            ptr_m  = (exp_g + 1) % NREQ;
            prev_x = 1; prev_q = gq; prev_m = gm;
        end else begin
            prev_x = 0;
        end
        while (issue_t.size() > 0 && issue_t[0] < cyc - 2 - LAT) issue_t.delete(0);
        en_h2 = en_h1;
        en_h1 = en;
        if (!rst_n) model_clear();
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0;
        bus.req_valid = '0; bus.req_q = '0; bus.req_m = '0;
        repeat (3) @(posedge clk);
        #1;
        model_clear();
        n_checks++;
        if (bus.req_ready !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ready got=%b exp=0000", bus.req_ready);
        end
        n_checks++;
        if ({bus.mul_start, bus.mul_q, bus.mul_m} !== 9'd0) begin
            n_fail++; $display("FAIL reset_mul got=%b/%h/%h exp=0/0/0", bus.mul_start, bus.mul_q, bus.mul_m);
        end
        n_checks++;
        if ({bus.resp_valid, bus.resp_data, bus.resp_id} !== 14'd0) begin
            n_fail++; $display("FAIL reset_resp got=%b/%h/%h exp=0/0/0", bus.resp_valid, bus.resp_data, bus.resp_id);
        end
        n_checks++;
        if (idle !== 1'b1) begin
            n_fail++; $display("FAIL reset_idle got=%b exp=1", idle);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int t_x, t_r, g;
        t_x = -100; t_r = -1;
        en = 1'b1;
        set_req(0, 0, 4'd0, 4'd0);
        for (int c = 0; c < LAT + 8; c++) begin
            if (c == 1) set_req(0, 1, 4'd3, 4'd5);
            settle();
            n_checks++;
            if (bus.req_ready !== exp_ready) begin
                n_fail++; $display("FAIL single_ready cyc=%0d got=%b exp=%b", cyc, bus.req_ready, exp_ready);
            end
            n_checks++;
            if ({bus.mul_start, bus.mul_q, bus.mul_m} !== {exp_start, exp_mq, exp_mm}) begin
                n_fail++; $display("FAIL single_mul cyc=%0d got=%b/%h/%h exp=%b/%h/%h", cyc, bus.mul_start, bus.mul_q, bus.mul_m, exp_start, exp_mq, exp_mm);
            end
            n_checks++;
            if ({bus.resp_valid, bus.resp_data, idle} !== {exp_rv, exp_rd, exp_idle}) begin
                n_fail++; $display("FAIL single_resp cyc=%0d got=%b/%h/%b exp=%b/%h/%b", cyc, bus.resp_valid, bus.resp_data, idle, exp_rv, exp_rd, exp_idle);
            end
            if (bus.req_valid[0] && bus.req_ready[0]) t_x = cyc;
            if (bus.resp_valid != '0 && t_r < 0) begin
                t_r = cyc;
                n_checks++;
                if ({bus.resp_valid, bus.resp_data, bus.resp_id} !== {4'b0001, 8'd15, 2'd0}) begin
                    n_fail++; $display("FAIL single_value got=%b/%0d/%0d exp=0001/15/0", bus.resp_valid, bus.resp_data, bus.resp_id);
                end
            end
            g = exp_g;
            advance();
            if (g == 0) set_req(0, 0, 4'd0, 4'd0);
        end
        n_checks++;
        if (t_r - t_x != LAT + 2) begin
            n_fail++; $display("FAIL single_latency got=%0d exp=%0d", t_r - t_x, LAT + 2);
        end
    endtask

    task automatic test_contention();
        for (int i = 0; i < NREQ; i++) set_req(i, 1, 4'(i + 1), 4'd15);
        for (int c = 0; c < 12 + LAT + 2; c++) begin
            if (c == 12) bus.req_valid = '0;
            settle();
            n_checks++;
            if (bus.req_ready !== exp_ready) begin
                n_fail++; $display("FAIL contention_ready cyc=%0d got=%b exp=%b", cyc, bus.req_ready, exp_ready);
            end
            n_checks++;
            if ({bus.mul_start, bus.mul_q, bus.mul_m} !== {exp_start, exp_mq, exp_mm}) begin
                n_fail++; $display("FAIL contention_mul cyc=%0d got=%b/%h/%h exp=%b/%h/%h", cyc, bus.mul_start, bus.mul_q, bus.mul_m, exp_start, exp_mq, exp_mm);
            end
            n_checks++;
            if ({bus.resp_valid, bus.resp_data, idle} !== {exp_rv, exp_rd, exp_idle}) begin
                n_fail++; $display("FAIL contention_resp cyc=%0d got=%b/%0d/%b exp=%b/%0d/%b", cyc, bus.resp_valid, bus.resp_data, idle, exp_rv, exp_rd, exp_idle);
            end
            if (exp_rv != '0) begin
                n_checks++;
                if (bus.resp_id !== exp_rid) begin
                    n_fail++; $display("FAIL contention_id cyc=%0d got=%0d exp=%0d", cyc, bus.resp_id, exp_rid);
                end
            end
            advance();
        end
    endtask

    task automatic test_wrap();
        int seq [4] = '{3, 1, 3, 1};
        logic [NREQ-1:0] want;
        bus.req_valid = '0;
        set_req(2, 1, 4'd7, 4'd2);
        for (int c = 0; c < 4 && ptr_m != 3; c++) begin
            settle();
            n_checks++;
            if (bus.req_ready !== exp_ready) begin
                n_fail++; $display("FAIL wrap_setup_ready cyc=%0d got=%b exp=%b", cyc, bus.req_ready, exp_ready);
            end
            advance();
        end
        bus.req_valid = '0;
        set_req(1, 1, 4'd9, 4'd9);
        set_req(3, 1, 4'd11, 4'd13);
        for (int c = 0; c < 4; c++) begin
            settle();
            want = 4'b0001 << seq[c];
            n_checks++;
            if (bus.req_ready !== want) begin
                n_fail++; $display("FAIL wrap_order step=%0d got=%b exp=%b", c, bus.req_ready, want);
            end
            n_checks++;
            if ({bus.resp_valid, bus.resp_data, idle} !== {exp_rv, exp_rd, exp_idle}) begin
                n_fail++; $display("FAIL wrap_resp cyc=%0d got=%b/%0d/%b exp=%b/%0d/%b", cyc, bus.resp_valid, bus.resp_data, idle, exp_rv, exp_rd, exp_idle);
            end
            advance();
        end
        bus.req_valid = '0;
    endtask

    task automatic test_drain();
        int last_r, first_i;
        last_r = -1; first_i = -1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        for (int c = 0; c < LAT + 14; c++) begin
            if (c == 3) en = 1'b0;
            settle();
            n_checks++;
            if (bus.req_ready !== exp_ready) begin
                n_fail++; $display("FAIL drain_ready cyc=%0d got=%b exp=%b", cyc, bus.req_ready, exp_ready);
            end
            n_checks++;
            if ({bus.mul_start, bus.mul_q, bus.mul_m} !== {exp_start, exp_mq, exp_mm}) begin
                n_fail++; $display("FAIL drain_mul cyc=%0d got=%b/%h/%h exp=%b/%h/%h", cyc, bus.mul_start, bus.mul_q, bus.mul_m, exp_start, exp_mq, exp_mm);
            end
            n_checks++;
            if ({bus.resp_valid, bus.resp_data, idle} !== {exp_rv, exp_rd, exp_idle}) begin
                n_fail++; $display("FAIL drain_resp cyc=%0d got=%b/%0d/%b exp=%b/%0d/%b", cyc, bus.resp_valid, bus.resp_data, idle, exp_rv, exp_rd, exp_idle);
            end
            if (bus.resp_valid != '0) last_r = cyc;
            if (idle === 1'b1 && first_i < 0) first_i = cyc;
            advance();
        end
        n_checks++;
        if (first_i - last_r != 1) begin
            n_fail++; $display("FAIL drain_idle_rise last_resp=%0d idle_at=%0d exp_gap=1", last_r, first_i);
        end
        bus.req_valid = '0;
    endtask

    task automatic test_reset_midflight();
        int seen;
        seen = 0;
        en = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) set_req(0, 1, 4'd15, 4'd15);
            if (c == 2) bus.req_valid = '0;
            if (c == 3) rst_n = 1'b0;
            settle();
            n_checks++;
            if ({bus.req_ready, bus.mul_q, bus.mul_m} !== {exp_ready, exp_mq, exp_mm}) begin
                n_fail++; $display("FAIL midrst_pre cyc=%0d got=%b/%h/%h exp=%b/%h/%h", cyc, bus.req_ready, bus.mul_q, bus.mul_m, exp_ready, exp_mq, exp_mm);
            end
            advance();
        end
        n_checks++;
        if ({bus.req_ready, bus.mul_start, bus.mul_q, bus.mul_m, bus.resp_valid, bus.resp_data, bus.resp_id, idle} !== {4'b0, 1'b0, 4'b0, 4'b0, 4'b0, 8'b0, 2'b0, 1'b1}) begin
            n_fail++; $display("FAIL midrst_values got=%b/%b/%h/%h/%b/%h/%h/%b exp=0000/0/0/0/0000/00/0/1", bus.req_ready, bus.mul_start, bus.mul_q, bus.mul_m, bus.resp_valid, bus.resp_data, bus.resp_id, idle);
        end
        rst_n = 1'b1;
        en = 1'b0;
        for (int c = 0; c < LAT + 6; c++) begin
            settle();
            if (bus.resp_valid != '0) seen++;
            n_checks++;
            if ({bus.resp_valid, bus.resp_data, idle} !== {exp_rv, exp_rd, exp_idle}) begin
                n_fail++; $display("FAIL midrst_resp cyc=%0d got=%b/%0d/%b exp=%b/%0d/%b", cyc, bus.resp_valid, bus.resp_data, idle, exp_rv, exp_rd, exp_idle);
            end
            advance();
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++; $display("FAIL midrst_ghost got=%0d responses exp=0", seen);
        end
    endtask

    task automatic test_random();
        int g;
        en = 1'b1;
        bus.req_valid = '0;
        for (int c = 0; c < 600; c++) begin
            if (c >= 580) en = 1'b0;
            else if ($urandom_range(0, 9) == 0) en = ~en;
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req_valid[i] && $urandom_range(0, 2) == 0) begin
                    set_req(i, 1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
                end
            end
            settle();
            n_checks++;
            if (bus.req_ready !== exp_ready) begin
                n_fail++; $display("FAIL random_ready cyc=%0d got=%b exp=%b", cyc, bus.req_ready, exp_ready);
            end
            n_checks++;
            if ({bus.mul_start, bus.mul_q, bus.mul_m} !== {exp_start, exp_mq, exp_mm}) begin
                n_fail++; $display("FAIL random_mul cyc=%0d got=%b/%h/%h exp=%b/%h/%h", cyc, bus.mul_start, bus.mul_q, bus.mul_m, exp_start, exp_mq, exp_mm);
            end
            n_checks++;
            if ({bus.resp_valid, bus.resp_data, idle} !== {exp_rv, exp_rd, exp_idle}) begin
                n_fail++; $display("FAIL random_resp cyc=%0d got=%b/%0d/%b exp=%b/%0d/%b", cyc, bus.resp_valid, bus.resp_data, idle, exp_rv, exp_rd, exp_idle);
            end
            if (exp_rv != '0) begin
                n_checks++;
                if (bus.resp_id !== exp_rid) begin
                    n_fail++; $display("FAIL random_id cyc=%0d got=%0d exp=%0d", cyc, bus.resp_id, exp_rid);
                end
            end
            g = exp_g;
            advance();
            if (g >= 0) set_req(g, 0, 4'd0, 4'd0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_wrap();
        test_drain();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
